// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller: op encodings, FSM states and default
// access timing.
package mem_bus_ctrl_pkg;

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WW  = 2'd1;
    localparam logic [1:0] OP_RSV = 2'd2;
    localparam logic [1:0] OP_WH  = 2'd3;

    localparam int unsigned DEF_RD_CYCLES = 5;
    localparam int unsigned DEF_WR_CYCLES = 3;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StTurn,
        StRsp
    } state_t;

endpackage

// File: rtl/mem_bus_ctrl.sv
// CPU-to-memory bus controller: one outstanding request, fixed-length read/write phases,
// a turnaround cycle after writes and a one-cycle response pulse.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned RD_CYCLES = DEF_RD_CYCLES,
    parameter int unsigned WR_CYCLES = DEF_WR_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        Memread,
    output logic [1:0]  Memwrite,
    output logic [14:0] Addrin,
    inout  wire  [31:0] BUS
);

    localparam int unsigned MAX_CYCLES = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic [14:0]      addrin_q;
    logic             memread_q, memread_d;
    logic [1:0]       memwrite_q, memwrite_d;
    logic             drive_q, drive_d;
    logic             accept;
    logic             capture;
    logic [1:0]       op_next;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                    case (req_op)
                        OP_RD:        state_d = StRd;
                        OP_WW, OP_WH: state_d = StWr;
                        default:      state_d = StRsp;
                    endcase
                end
            end
            StRd: begin
                if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_d = StRsp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWr: begin
                if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
                    state_d = StTurn;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTurn:  state_d = StRsp;
            StRsp:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus strobes are registered from the next state so they stay glitch-free and exclusive.
    always_comb begin
        op_next    = accept ? req_op : op_q;
        memread_d  = (state_d == StRd);
        memwrite_d = (state_d == StWr) ? op_next : 2'b00;
        drive_d    = (state_d == StWr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= OP_RD;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addrin_q   <= '0;
            memread_q  <= 1'b0;
            memwrite_q <= 2'b00;
            drive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            drive_q    <= drive_d;
            if (accept) begin
                op_q    <= req_op;
                wdata_q <= req_wdata;
                // Reserved ops never reach memory, so Addrin keeps its previous value.
                if (req_op != OP_RSV) begin
                    addrin_q <= req_addr;
                end
            end
            if (capture) begin
                rdata_q <= BUS;
            end
        end
    end

    assign BUS = drive_q ? wdata_q : 32'bz;

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StRsp);
    assign rsp_err   = rsp_valid && (op_q == OP_RSV);
    assign rsp_rdata = rdata_q;
    assign Memread   = memread_q;
    assign Memwrite  = memwrite_q;
    assign Addrin    = addrin_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, hand-written corner sequences
// and random transactions checked cycle by cycle against an op/latency model.
module tb_mem_bus_ctrl;

    localparam int unsigned RD = 5;
    localparam int unsigned WR = 3;
    localparam logic [31:0] SENTINEL = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        Memread;
    logic [1:0]  Memwrite;
    logic [14:0] Addrin;
    wire  [31:0] bus;

    int checks = 0;
    int errors = 0;

    logic [14:0] model_addrin;
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        if (a == 15'h0004) return 32'hDEAD_BEEF;
        return {a, 2'b10, ~a};
    endfunction

    // Memory returns data while Memread is high; otherwise a weak "idle" pattern stands in for
    // high-Z so that any stray DUT drive shows up as a corrupted value.
    assign bus = (Memwrite != 2'b00) ? 32'bz : (Memread ? mem_word(Addrin) : SENTINEL);

    mem_bus_ctrl #(
        .RD_CYCLES (RD),
        .WR_CYCLES (WR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Memread   (Memread),
        .Memwrite  (Memwrite),
        .Addrin    (Addrin),
        .BUS       (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] observe();
        return 128'({req_ready, rsp_valid, rsp_err, Memread, Memwrite, Addrin, bus, rsp_rdata});
    endfunction

    function automatic logic [127:0] pack(input logic rdy, input logic rv, input logic er,
                                          input logic mr, input logic [1:0] mw,
                                          input logic [14:0] ad, input logic [31:0] bv,
                                          input logic [31:0] rd);
        return 128'({rdy, rv, er, mr, mw, ad, bv, rd});
    endfunction

    task automatic wait_ready(input string name);
        for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
        if (!req_ready) check({name, "_ready_timeout"}, 128'(req_ready), 128'(1));
    endtask

    // One full transaction; every cycle until the response is compared with the expected
    // bus activity derived from the op and the fixed phase lengths.
    task automatic run_txn(input int id, input logic [1:0] op, input logic [14:0] addr,
                           input logic [31:0] wdata, output int lat, output logic err,
                           output logic [31:0] rdata);
        logic        is_rd, is_wr;
        int          exp_lat;
        logic        e_mr;
        logic [1:0]  e_mw;
        logic [14:0] e_ad;
        logic [31:0] e_bus, e_rd;
        is_rd   = (op == 2'd0);
        is_wr   = (op == 2'd1) || (op == 2'd3);
        exp_lat = is_rd ? RD + 1 : (is_wr ? WR + 2 : 1);
        lat     = -1;
        err     = 1'b0;
        rdata   = '0;
        wait_ready($sformatf("txn%0d", id));
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        if (is_rd || is_wr) model_addrin = addr;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_op    = 2'($urandom);
            req_addr  = 15'($urandom);
            e_mr  = is_rd && (k <= RD);
            e_mw  = (is_wr && (k <= WR)) ? op : 2'b00;
            e_ad  = model_addrin;
            e_bus = (e_mw != 2'b00) ? wdata : (e_mr ? mem_word(addr) : SENTINEL);
            e_rd  = (is_rd && k == exp_lat) ? mem_word(addr) : model_rdata;
            check($sformatf("txn%0d_cycle%0d", id, k), observe(),
                  pack(1'b0, k == exp_lat, (k == exp_lat) && op == 2'd2, e_mr, e_mw, e_ad,
                       e_bus, e_rd));
            if (rsp_valid) begin
                lat   = k;
                err   = rsp_err;
                rdata = rsp_rdata;
                break;
            end
        end
        if (lat < 0) check($sformatf("txn%0d_rsp_timeout", id), 128'(0), 128'(1));
        if (is_rd) model_rdata = mem_word(addr);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [14:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          acc_k, wr_rsp_k, rd_rsp_k, ready_hi_early, overlap, rv_seen;
        logic [31:0] rd_val;

        vecs[0] = '{op: 2'd0, addr: 15'h0004, wdata: 32'h0, lat: 6, err: 1'b0,
                    chk_rd: 1'b1, rdata: 32'hDEAD_BEEF};
        vecs[1] = '{op: 2'd3, addr: 15'h0003, wdata: 32'h0000_ABCD, lat: 5, err: 1'b0,
                    chk_rd: 1'b0, rdata: 32'h0};
        vecs[2] = '{op: 2'd2, addr: 15'h0100, wdata: 32'h1234_5678, lat: 1, err: 1'b1,
                    chk_rd: 1'b0, rdata: 32'h0};
        vecs[3] = '{op: 2'd1, addr: 15'h7FFF, wdata: 32'hCAFE_F00D, lat: 5, err: 1'b0,
                    chk_rd: 1'b0, rdata: 32'h0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'd0;
        req_addr = '0;
        req_wdata = '0;
        model_addrin = '0;
        model_rdata = '0;
        repeat (2) @(negedge clk);
        check("reset_state", observe(),
              pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0, SENTINEL, 32'h0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", observe(),
              pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0, SENTINEL, 32'h0));

        for (int i = 0; i < 4; i++) begin
            run_txn(i, vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, err, rdata);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
            check($sformatf("vec%0d_err", i), 128'(err), 128'(vecs[i].err));
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), 128'(rdata),
                                      128'(vecs[i].rdata));
        end

        // Back-to-back: word write then read with req_valid held high throughout.
        wait_ready("b2b");
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_addr  = 15'h0020;
        req_wdata = 32'h1357_9BDF;
        acc_k = -1; wr_rsp_k = -1; rd_rsp_k = -1;
        ready_hi_early = 0; overlap = 0; rd_val = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_op   = 2'd0;
                req_addr = 15'h0004;
            end
            if (Memread && Memwrite != 2'b00) overlap++;
            if (rsp_valid && wr_rsp_k < 0) wr_rsp_k = k;
            else if (rsp_valid && rd_rsp_k < 0) begin
                rd_rsp_k = k;
                rd_val   = rsp_rdata;
            end
            if (req_ready && acc_k < 0) begin
                acc_k = k;
                if (rsp_valid) ready_hi_early++;
            end else if (req_ready && acc_k >= 0 && k == acc_k + 1) begin
                ready_hi_early++;
            end
            if (k < WR + 3 && req_ready) ready_hi_early++;
            if (k == acc_k + 1 && acc_k > 0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        model_addrin = 15'h0004;
        model_rdata  = 32'hDEAD_BEEF;
        check("b2b_write_rsp_cycle", 128'(wr_rsp_k), 128'(WR + 2));
        check("b2b_read_accept_cycle", 128'(acc_k), 128'(WR + 3));
        check("b2b_ready_low_while_busy", 128'(ready_hi_early), 128'(0));
        check("b2b_read_rsp_cycle", 128'(rd_rsp_k), 128'(WR + 3 + RD + 1));
        check("b2b_read_data", 128'(rd_val), 128'(32'hDEAD_BEEF));
        check("b2b_no_overlap", 128'(overlap), 128'(0));
        @(negedge clk);

        // Reset asserted during the second read cycle abandons the read.
        wait_ready("rst_mid");
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_addr  = 15'h0010;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_addrin = '0;
        model_rdata  = '0;
        check("rst_mid_read_state", observe(),
              pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0, SENTINEL, 32'h0));
        rst = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid || Memread || !req_ready) rv_seen++;
        end
        check("rst_mid_no_response", 128'(rv_seen), 128'(0));

        for (int i = 0; i < 40; i++) begin
            run_txn(100 + i, 2'($urandom_range(0, 3)), 15'($urandom), $urandom, lat, err,
                    rdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
